// File: rtl/ahbl_req_master.sv
`timescale 1ns/1ps
// ahbl_req_master
// Turns a valid/ready request stream into single AHB-lite transfers. Each
// transfer's read data and error status come back on a registered response
// port, in request order. Address and data phases overlap, so a stream of
// requests issues one transfer per cycle when the slave inserts no wait states.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_*                 request stream (valid/ready handshake)
//   resp_valid/rdata/err  one-cycle response pulse per completed transfer
//   busy                  a transfer is in flight or a response is pending
//   ahblm_*               AHB-lite master interface
module ahbl_req_master #(
    parameter int unsigned W_DATA = 32,
    parameter int unsigned W_ADDR = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic [W_ADDR-1:0] req_addr,
    input  logic              req_write,
    input  logic [2:0]        req_size,
    input  logic [W_DATA-1:0] req_wdata,

    output logic              resp_valid,
    output logic [W_DATA-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy,

    output logic [W_ADDR-1:0] ahblm_haddr,
    output logic              ahblm_hwrite,
    output logic [1:0]        ahblm_htrans,
    output logic [2:0]        ahblm_hsize,
    output logic [2:0]        ahblm_hburst,
    output logic [3:0]        ahblm_hprot,
    output logic              ahblm_hmastlock,
    output logic [W_DATA-1:0] ahblm_hwdata,
    input  logic              ahblm_hready,
    input  logic              ahblm_hresp,
    input  logic [W_DATA-1:0] ahblm_hrdata
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DATA    = 4'b0011;

    // Address-phase stage
    logic              aph_valid_q, aph_valid_d;
    logic [W_ADDR-1:0] aph_addr_q,  aph_addr_d;
    logic              aph_write_q, aph_write_d;
    logic [2:0]        aph_size_q,  aph_size_d;
    logic [W_DATA-1:0] aph_wdata_q, aph_wdata_d;

    // Data-phase stage
    logic              dph_valid_q, dph_valid_d;
    logic              dph_write_q, dph_write_d;
    logic [W_DATA-1:0] dph_wdata_q, dph_wdata_d;

    // Response register
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q,   resp_err_d;
    logic [W_DATA-1:0] resp_rdata_q, resp_rdata_d;

    logic              load_aph;

    // An empty address stage may load even under a stall: htrans is IDLE there.
    assign req_ready = !aph_valid_q || ahblm_hready;
    assign load_aph  = req_valid && req_ready;

    // Next-state for both pipeline stages and the response register
    always_comb begin
        aph_valid_d  = aph_valid_q;
        aph_addr_d   = aph_addr_q;
        aph_write_d  = aph_write_q;
        aph_size_d   = aph_size_q;
        aph_wdata_d  = aph_wdata_q;
        dph_valid_d  = dph_valid_q;
        dph_write_d  = dph_write_q;
        dph_wdata_d  = dph_wdata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;

        // Address stage stays full while stalled, otherwise takes the new request
        aph_valid_d = load_aph || (aph_valid_q && !ahblm_hready);
        if (load_aph) begin
            aph_addr_d  = req_addr;
            aph_write_d = req_write;
            aph_size_d  = req_size;
            aph_wdata_d = req_wdata;
        end

        if (ahblm_hready) begin
            dph_valid_d = aph_valid_q;
            // Keep last payload when idle so hwdata does not toggle needlessly
            if (aph_valid_q) begin
                dph_write_d = aph_write_q;
                dph_wdata_d = aph_wdata_q;
            end
            if (dph_valid_q) begin
                resp_valid_d = 1'b1;
                resp_err_d   = ahblm_hresp;
                resp_rdata_d = dph_write_q ? '0 : ahblm_hrdata;
            end
        end
    end

    // Pipeline and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aph_valid_q  <= 1'b0;
            aph_addr_q   <= '0;
            aph_write_q  <= 1'b0;
            aph_size_q   <= 3'b000;
            aph_wdata_q  <= '0;
            dph_valid_q  <= 1'b0;
            dph_write_q  <= 1'b0;
            dph_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            aph_valid_q  <= aph_valid_d;
            aph_addr_q   <= aph_addr_d;
            aph_write_q  <= aph_write_d;
            aph_size_q   <= aph_size_d;
            aph_wdata_q  <= aph_wdata_d;
            dph_valid_q  <= dph_valid_d;
            dph_write_q  <= dph_write_d;
            dph_wdata_q  <= dph_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Bus and response outputs, all straight from flops
    assign ahblm_htrans    = aph_valid_q ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign ahblm_haddr     = aph_addr_q;
    assign ahblm_hwrite    = aph_write_q;
    assign ahblm_hsize     = aph_size_q;
    assign ahblm_hburst    = HBURST_SINGLE;
    assign ahblm_hprot     = HPROT_DATA;
    assign ahblm_hmastlock = 1'b0;
    assign ahblm_hwdata    = dph_wdata_q;

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign busy       = aph_valid_q || dph_valid_q || resp_valid_q;

endmodule
